// File: rtl/bit_stream_packer.sv
// Packs a framed serial bitstream into LEN_DATA-bit words with last/bit-count tags.
// Optional MSB_FIRST_EN: place the k-th bit of a word at LEN_DATA-1-k (left-aligned partials).
module bit_stream_packer #(
  parameter int FF_DLY   = 1,
  parameter int LEN_DATA = 32,
  parameter int LEN_IDX  = 5,
  parameter int INTL     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  input  logic                 sof,
  input  logic                 eof,
  output logic [LEN_DATA-1:0]  data,
  output logic                 data_enb,
  output logic                 data_last,
  output logic [LEN_IDX:0]     data_nbits,
  output logic                 frame_err
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [LEN_IDX-1:0] LAST_IDX = LEN_IDX'(LEN_DATA - 1);

  // Register delays are a simulation-model convention only; these flops carry none.
  if (FF_DLY < 0) begin : g_ff_dly_unused
  end

  state_t               state_q, state_d;
  logic [LEN_IDX-1:0]   idx_q, idx_d;
  logic [LEN_DATA-1:0]  shreg_q, shreg_d;
  logic [LEN_DATA-1:0]  data_q, data_d;
  logic                 data_enb_q, data_enb_d;
  logic                 data_last_q, data_last_d;
  logic [LEN_IDX:0]     data_nbits_q, data_nbits_d;
  logic                 frame_err_q, frame_err_d;

  logic                 accept;
  logic [LEN_IDX-1:0]   base_idx;
  logic [LEN_DATA-1:0]  base_word;
  logic [LEN_IDX-1:0]   pos;
  logic [LEN_DATA-1:0]  word_next;
  logic                 word_full;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    data_last_d  = data_last_q;
    data_nbits_d = data_nbits_q;
    data_enb_d   = 1'b0;
    frame_err_d  = 1'b0;

    accept = bit_vld && ((state_q == FILL) || sof);

    // A sof bit always begins a fresh word at index 0, discarding any partial one.
    base_idx  = sof ? '0 : idx_q;
    base_word = sof ? '0 : shreg_q;

`ifdef MSB_FIRST_EN
    pos = LAST_IDX - base_idx;
`else
    pos = base_idx;
`endif

    word_next = base_word | (LEN_DATA'(bit_in) << pos);
    word_full = (base_idx == LAST_IDX);

    if (accept) begin
      if (sof && (state_q == FILL) && (idx_q != '0)) begin
        frame_err_d = 1'b1;
      end

      if (eof || word_full) begin
        data_d       = word_next;
        data_enb_d   = 1'b1;
        data_last_d  = eof;
        data_nbits_d = (LEN_IDX+1)'(base_idx) + (LEN_IDX+1)'(1);
        shreg_d      = '0;
        idx_d        = '0;
      end else begin
        shreg_d = word_next;
        idx_d   = base_idx + LEN_IDX'(1);
      end

      state_d = eof ? IDLE : FILL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is a plain flop bank, so it is reset along with the control state.
      state_q      <= IDLE;
      idx_q        <= LEN_IDX'(INTL);
      shreg_q      <= LEN_DATA'(INTL);
      data_q       <= LEN_DATA'(INTL);
      data_enb_q   <= 1'(INTL);
      data_last_q  <= 1'(INTL);
      data_nbits_q <= (LEN_IDX+1)'(INTL);
      frame_err_q  <= 1'(INTL);
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      data_enb_q   <= data_enb_d;
      data_last_q  <= data_last_d;
      data_nbits_q <= data_nbits_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data       = data_q;
  assign data_enb   = data_enb_q;
  assign data_last  = data_last_q;
  assign data_nbits = data_nbits_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/bit_stream_packer.md
Name: bit_stream_packer

Overview:
Serial-to-parallel front end for the bit block counting path. Collects a framed serial bitstream (one bit per cycle max) into LEN_DATA-bit words. Presents each completed word with a one-cycle data_enb pulse, directly driving the data/data_enb inputs of the downstream bit block counter. The final partial word of a frame is zero-padded and tagged with last/bit-count information.

Parameters:
FF_DLY, 1, simulation delay on all register assignments
LEN_DATA, 32, output word width in bits
LEN_IDX, 5, log2(LEN_DATA); width of the bit index
INTL, 0, reset value for all registers

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
bit_in  input  1  serial data bit
bit_vld  input  1  bit_in valid this cycle
sof  input  1  start of frame; qualified by bit_vld; marks the first bit of a frame
eof  input  1  end of frame; qualified by bit_vld; marks the last bit of a frame
data  output  LEN_DATA  packed word
data_enb  output  1  one-cycle pulse: data valid
data_last  output  1  word is last of frame; valid with data_enb
data_nbits  output  LEN_IDX+1  valid bits in word, 1..LEN_DATA; valid with data_enb
frame_err  output  1  one-cycle pulse: frame aborted

Behaviour:
- Reset: all outputs 0; FSM in IDLE; shift register and bit index cleared. Async assert, sync release by clk.
- Accepted bit: a bit is accepted when bit_vld=1 and either the FSM is in FILL, or sof=1.
- Ignored bits: bit_vld=1 in IDLE with sof=0 is ignored. Accepted bits are counted nowhere else.
- FSM states:
  - IDLE: waits for bit_vld&sof; goes to FILL, or stays in IDLE if eof is also set.
  - FILL: accumulates bits; on accepted eof, returns to IDLE after emitting.
- Bit placement (default): the k-th accepted bit of a word (k=0..LEN_DATA-1) goes to bit k, LSB first. Unfilled bits are 0.
- Full word: on acceptance of bit k=LEN_DATA-1, the word is emitted:
  - Next cycle: data=word, data_enb=1, data_nbits=LEN_DATA, data_last=eof of that bit.
  - Bit index wraps to 0; filling continues with no bubble.
- eof on bit k<LEN_DATA-1: the word is emitted next cycle, zero-padded above bit k, with data_nbits=k+1 and data_last=1.
- sof&eof on the same accepted bit: 1-bit frame; the word is emitted with data_nbits=1 and data_last=1.
- sof in FILL:
  - If the bit index is 0, this is a back-to-back frame: no error, and the bit starts the new frame.
  - If the bit index is nonzero, the partial word is discarded (no data_enb), frame_err pulses next cycle, and the bit starts the new frame at index 0.
- Latency: exactly 1 cycle from the completing bit to data_enb. data is held until the next emission. data_enb, frame_err: single-cycle pulses.
- Throughput: at most one bit per cycle, so at most one emission per LEN_DATA cycles, except short frames (one emission per eof).
- Idle gaps: bit_vld=0 cycles in FILL hold state; there is no timeout.
- Reset mid-frame: the partial word is lost; no emission and no frame_err.

Optional Feature:
MSB_FIRST_EN
- Defined: the k-th accepted bit goes to bit LEN_DATA-1-k. A partial word is left-aligned, with zero padding in the low bits. data_nbits and data_last are unchanged.
- Undefined: LSB-first placement as above.

Test Plan:
1. Reset, then 32 accepted bits of pattern 0xF0F0_3C3C LSB-first, sof on bit 0, eof on bit 31. Required: 1 cycle later data=0xF0F03C3C, data_enb=1, data_nbits=32, data_last=1; data_enb low on the following cycle.
2. 40-bit frame, all ones. Required: first word 0xFFFFFFFF with nbits=32 and last=0; second word 0x000000FF with nbits=8 and last=1.
3. Bits 1,0,1 with bit_vld toggling 1,0,1,0,1 and eof on the third bit. Required: a single emission data=0x00000005, nbits=3, last=1.
4. Start a frame, accept 10 bits, then sof with bit 1. Required: frame_err pulse next cycle, no data_enb. If eof is asserted immediately on that bit: data=0x1, nbits=1.
5. bit_vld=1 for 8 cycles in IDLE without sof. Required: no data_enb and no frame_err; the next sof frame starts at index 0.
6. With MSB_FIRST_EN, scenario 3. Required: data=0xA0000000, nbits=3. Additionally, assert rst_n=0 mid-frame: all outputs go 0 immediately, with no emission.
